// File: rtl/kalman_mat2_mac.sv
// kalman_mat2_mac: sequential 2x2 signed fixed-point engine computing C = A*op(B) + D.
// One shared multiplier and one accumulator; one product per clock, two products per element.
module kalman_mat2_mac #(
  parameter int W    = 16,
  parameter int FRAC = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                transpose_b,
  input  logic                add_en,
  input  logic signed [W-1:0] a00,
  input  logic signed [W-1:0] a01,
  input  logic signed [W-1:0] a10,
  input  logic signed [W-1:0] a11,
  input  logic signed [W-1:0] b00,
  input  logic signed [W-1:0] b01,
  input  logic signed [W-1:0] b10,
  input  logic signed [W-1:0] b11,
  input  logic signed [W-1:0] d00,
  input  logic signed [W-1:0] d01,
  input  logic signed [W-1:0] d10,
  input  logic signed [W-1:0] d11,
  output logic signed [W-1:0] c00,
  output logic signed [W-1:0] c01,
  output logic signed [W-1:0] c10,
  output logic signed [W-1:0] c11,
  output logic                busy,
  output logic                done,
  output logic                sat
);

  // Accumulator is 2W+2 bits: two full products plus shifted D plus rounding cannot overflow it.
  localparam int ACC_W = 2 * W + 2;
  localparam logic signed [ACC_W-1:0] RND_C   = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_r;
  state_t                    state_next_s;
  logic [2:0]                k_r;
  logic                      transpose_r;
  logic                      add_en_r;
  logic                      busy_r;
  logic                      done_r;
  logic                      sat_r;
  logic signed [ACC_W-1:0]   acc_r;
  logic signed [W-1:0]       a_r [4];
  logic signed [W-1:0]       b_r [4];
  logic signed [W-1:0]       d_r [4];
  logic signed [W-1:0]       c_r [4];
  logic signed [W-1:0]       a_in_s [4];
  logic signed [W-1:0]       b_in_s [4];
  logic signed [W-1:0]       d_in_s [4];

  logic [1:0]                elem_s;
  logic [1:0]                ob_idx_s;
  logic signed [2*W-1:0]     a_ext_s;
  logic signed [2*W-1:0]     b_ext_s;
  logic signed [2*W-1:0]     mul_s;
  logic signed [ACC_W-1:0]   mul_acc_s;
  logic signed [ACC_W-1:0]   d_term_s;
  logic signed [ACC_W-1:0]   sum_s;
  logic signed [ACC_W-1:0]   shift_s;

  // Sign-extend an operand to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_acc(input logic signed [W-1:0] v);
    return {{(ACC_W-W){v[W-1]}}, v};
  endfunction

  // Clamp an accumulator-width value into the W-bit signed result range.
  function automatic logic signed [W-1:0] sat_w(input logic signed [ACC_W-1:0] v);
    if (v > SAT_MAX) begin
      return SAT_MAX[W-1:0];
    end else if (v < SAT_MIN) begin
      return SAT_MIN[W-1:0];
    end else begin
      return v[W-1:0];
    end
  endfunction

  // Report whether sat_w would clamp the value.
  function automatic logic sat_hit(input logic signed [ACC_W-1:0] v);
    return (v > SAT_MAX) || (v < SAT_MIN);
  endfunction

  assign a_in_s[0] = a00;
  assign a_in_s[1] = a01;
  assign a_in_s[2] = a10;
  assign a_in_s[3] = a11;
  assign b_in_s[0] = b00;
  assign b_in_s[1] = b01;
  assign b_in_s[2] = b10;
  assign b_in_s[3] = b11;
  assign d_in_s[0] = d00;
  assign d_in_s[1] = d01;
  assign d_in_s[2] = d10;
  assign d_in_s[3] = d11;

  assign c00  = c_r[0];
  assign c01  = c_r[1];
  assign c10  = c_r[2];
  assign c11  = c_r[3];
  assign busy = busy_r;
  assign done = done_r;
  assign sat  = sat_r;

  // Next-state logic: IDLE waits for start, MAC runs k=0..7, DONE lasts one cycle.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = MAC;
        end else begin
          state_next_s = IDLE;
        end
      end
      MAC: begin
        if (k_r == 3'd7) begin
          state_next_s = DONE;
        end else begin
          state_next_s = MAC;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Product selection: k[2] is the row, k[1] the column, k[0] the inner index of A*op(B).
  always_comb begin
    elem_s = k_r[2:1];
    if (transpose_r) begin
      ob_idx_s = {k_r[1], k_r[0]};
    end else begin
      ob_idx_s = {k_r[0], k_r[1]};
    end
    a_ext_s   = {{W{a_r[{k_r[2], k_r[0]}][W-1]}}, a_r[{k_r[2], k_r[0]}]};
    b_ext_s   = {{W{b_r[ob_idx_s][W-1]}}, b_r[ob_idx_s]};
    mul_s     = a_ext_s * b_ext_s;
    mul_acc_s = {{2{mul_s[2*W-1]}}, mul_s};
    if (add_en_r) begin
      d_term_s = sext_acc(d_r[elem_s]) <<< FRAC;
    end else begin
      d_term_s = '0;
    end
    sum_s   = acc_r + mul_acc_s + d_term_s + RND_C;
    shift_s = sum_s >>> FRAC;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand latch, accumulator, result registers and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_r         <= 3'd0;
      transpose_r <= 1'b0;
      add_en_r    <= 1'b0;
      acc_r       <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      sat_r       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        a_r[i] <= '0;
        b_r[i] <= '0;
        d_r[i] <= '0;
        c_r[i] <= '0;
      end
    end else begin
      busy_r <= (state_r == MAC) || (state_r == DONE);
      done_r <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            transpose_r <= transpose_b;
            add_en_r    <= add_en;
            sat_r       <= 1'b0;
            k_r         <= 3'd0;
            for (int i = 0; i < 4; i++) begin
              a_r[i] <= a_in_s[i];
              b_r[i] <= b_in_s[i];
              d_r[i] <= d_in_s[i];
            end
          end
        end
        MAC: begin
          k_r <= k_r + 3'd1;
          if (!k_r[0]) begin
            acc_r <= mul_acc_s;
          end else begin
            c_r[elem_s] <= sat_w(shift_s);
            if (sat_hit(shift_s)) begin
              sat_r <= 1'b1;
            end
          end
        end
        default: begin
          k_r <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kalman_mat2_mac.sv
// tb_kalman_mat2_mac: randomized and directed checks of the 2x2 MAC engine against
// an integer reference model of C = A*op(B) + D with round-half-up and saturation.
module tb_kalman_mat2_mac;

  localparam int    W     = 16;
  localparam int    FRAC  = 13;
  localparam longint SCALE = 64'sd1 << FRAC;
  localparam longint HALF  = SCALE / 64'sd2;
  localparam longint MAXV  = (64'sd1 << (W - 1)) - 64'sd1;
  localparam longint MINV  = -(64'sd1 << (W - 1));

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                transpose_b;
  logic                add_en;
  logic signed [W-1:0] a_s [4];
  logic signed [W-1:0] b_s [4];
  logic signed [W-1:0] d_s [4];
  logic signed [W-1:0] c00, c01, c10, c11;
  logic                busy, done, sat;

  int checks = 0;
  int errors = 0;
  int op_a [4];
  int op_b [4];
  int op_d [4];
  bit op_tr, op_add;
  int exp_c [4];
  bit exp_sat;
  int obs_c [4];
  bit obs_sat;
  int done_edge, busy_cnt, done_cnt;

  always #5 clk = ~clk;

  kalman_mat2_mac #(.W(W), .FRAC(FRAC)) dut (
    .clk(clk), .reset(reset), .start(start), .transpose_b(transpose_b), .add_en(add_en),
    .a00(a_s[0]), .a01(a_s[1]), .a10(a_s[2]), .a11(a_s[3]),
    .b00(b_s[0]), .b01(b_s[1]), .b10(b_s[2]), .b11(b_s[3]),
    .d00(d_s[0]), .d01(d_s[1]), .d10(d_s[2]), .d11(d_s[3]),
    .c00(c00), .c01(c01), .c10(c10), .c11(c11),
    .busy(busy), .done(done), .sat(sat)
  );

  // Reference: each element is the real-valued dot product scaled by 2^FRAC,
  // rounded half-up via floor(x + 0.5), then clamped to the W-bit range.
  task automatic model();
    longint s, q;
    int ob0, ob1;
    exp_sat = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        ob0 = op_tr ? op_b[c * 2 + 0] : op_b[0 + c];
        ob1 = op_tr ? op_b[c * 2 + 1] : op_b[2 + c];
        s = longint'(op_a[r * 2]) * ob0 + longint'(op_a[r * 2 + 1]) * ob1 + HALF;
        if (op_add) s = s + longint'(op_d[r * 2 + c]) * SCALE;
        q = s / SCALE;
        if ((s % SCALE != 0) && (s < 0)) q = q - 1;
        if (q > MAXV) begin
          q = MAXV;
          exp_sat = 1'b1;
        end else if (q < MINV) begin
          q = MINV;
          exp_sat = 1'b1;
        end
        exp_c[r * 2 + c] = int'(q);
      end
    end
  endtask

  task automatic set_ops(input int a0, a1, a2, a3, b0, b1, b2, b3, d0, d1, d2, d3,
                         input bit tr, input bit ad);
    op_a = '{a0, a1, a2, a3};
    op_b = '{b0, b1, b2, b3};
    op_d = '{d0, d1, d2, d3};
    op_tr = tr;
    op_add = ad;
  endtask

  task automatic rand_ops(input int lim);
    for (int i = 0; i < 4; i++) begin
      op_a[i] = int'($urandom_range(0, 2 * lim - 1)) - lim;
      op_b[i] = int'($urandom_range(0, 2 * lim - 1)) - lim;
      op_d[i] = int'($urandom_range(0, 65535)) - 32768;
    end
    op_tr = bit'($urandom_range(0, 1));
    op_add = bit'($urandom_range(0, 1));
  endtask

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      a_s[i] = W'(op_a[i]);
      b_s[i] = W'(op_b[i]);
      d_s[i] = W'(op_d[i]);
    end
    transpose_b = op_tr;
    add_en = op_add;
  endtask

  task automatic capture();
    obs_c[0] = int'(c00);
    obs_c[1] = int'(c01);
    obs_c[2] = int'(c10);
    obs_c[3] = int'(c11);
    obs_sat = sat;
  endtask

  // One start pulse, then 14 observed edges; optionally a second start mid-operation.
  task automatic run_op(input int poke_edge);
    apply();
    model();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_edge = -1;
    busy_cnt = 0;
    done_cnt = 0;
    for (int e = 1; e <= 14; e++) begin
      @(posedge clk); #1;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_edge < 0) begin
          done_edge = e;
          capture();
        end
      end
      if (e == poke_edge) begin
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
          a_s[i] = W'($urandom);
          b_s[i] = W'($urandom);
          d_s[i] = W'($urandom);
        end
        transpose_b = ~transpose_b;
        add_en = ~add_en;
      end else begin
        start = 1'b0;
      end
    end
    if (done_edge < 0) capture();
  endtask

  task automatic test_reset();
    checks++;
    if ({c00, c01, c10, c11} !== {(4 * W){1'b0}}) begin
      errors++; $display("FAIL reset_c: got %h expected 0", {c00, c01, c10, c11});
    end
    checks++;
    if ({busy, done, sat} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got busy/done/sat=%b expected 000", {busy, done, sat});
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL idle_after_reset: got busy/done=%b expected 00", {busy, done});
    end
  endtask

  task automatic test_identity();
    set_ops(8192, 0, 0, 8192, 100, -200, 300, 8191, 0, 0, 0, 0, 1'b0, 1'b0);
    run_op(0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_c[i] !== exp_c[i]) begin
        errors++; $display("FAIL identity c[%0d]: got %0d expected %0d", i, obs_c[i], exp_c[i]);
      end
    end
    checks++;
    if (obs_sat !== 1'b0) begin errors++; $display("FAIL identity sat: got %0d expected 0", obs_sat); end
    checks++;
    if (done_edge !== 9) begin errors++; $display("FAIL identity done_edge: got %0d expected 9", done_edge); end
    checks++;
    if (busy_cnt !== 9) begin errors++; $display("FAIL identity busy_cycles: got %0d expected 9", busy_cnt); end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL identity done_pulses: got %0d expected 1", done_cnt); end
  endtask

  task automatic test_transpose();
    for (int t = 0; t < 2; t++) begin
      set_ops(8192, 8192, 0, 8192, 4096, 0, 4096, 4096, 0, 0, 0, 0, bit'(1 - t), 1'b0);
      run_op(0);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_c[i] !== exp_c[i]) begin
          errors++; $display("FAIL transpose%0d c[%0d]: got %0d expected %0d", 1 - t, i, obs_c[i], exp_c[i]);
        end
      end
      checks++;
      if (done_edge !== 9) begin errors++; $display("FAIL transpose done_edge: got %0d expected 9", done_edge); end
    end
  endtask

  task automatic test_add_round();
    for (int t = 0; t < 3; t++) begin
      case (t)
        0:       set_ops(8192, 0, 0, 8192, 0, 0, 0, 0, 1, 2, -3, 4, 1'b0, 1'b1);
        1:       set_ops(1, 0, 0, 0, 4096, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
        default: set_ops(1, 0, 0, 0, 4095, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      endcase
      run_op(0);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_c[i] !== exp_c[i]) begin
          errors++; $display("FAIL add_round%0d c[%0d]: got %0d expected %0d", t, i, obs_c[i], exp_c[i]);
        end
      end
      checks++;
      if (obs_sat !== 1'b0) begin errors++; $display("FAIL add_round%0d sat: got %0d expected 0", t, obs_sat); end
    end
  endtask

  task automatic test_saturation();
    for (int t = 0; t < 3; t++) begin
      case (t)
        0:       set_ops(32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 0, 0, 0, 0, 1'b0, 1'b0);
        1:       set_ops(-32768, -32768, -32768, -32768, 32767, 32767, 32767, 32767, 0, 0, 0, 0, 1'b0, 1'b0);
        default: set_ops(8192, 0, 0, 8192, 5, 6, 7, 8, 0, 0, 0, 0, 1'b0, 1'b0);
      endcase
      run_op(0);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_c[i] !== exp_c[i]) begin
          errors++; $display("FAIL saturation%0d c[%0d]: got %0d expected %0d", t, i, obs_c[i], exp_c[i]);
        end
      end
      checks++;
      if (obs_sat !== exp_sat) begin
        errors++; $display("FAIL saturation%0d sat: got %0d expected %0d", t, obs_sat, exp_sat);
      end
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      rand_ops((t % 2 == 0) ? 32768 : 12000);
      run_op(0);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_c[i] !== exp_c[i]) begin
          errors++; $display("FAIL random%0d c[%0d]: got %0d expected %0d", t, i, obs_c[i], exp_c[i]);
        end
      end
      checks++;
      if (obs_sat !== exp_sat) begin
        errors++; $display("FAIL random%0d sat: got %0d expected %0d", t, obs_sat, exp_sat);
      end
    end
  endtask

  task automatic test_busy_protection();
    rand_ops(12000);
    run_op(3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_c[i] !== exp_c[i]) begin
        errors++; $display("FAIL busy_protect c[%0d]: got %0d expected %0d", i, obs_c[i], exp_c[i]);
      end
    end
    checks++;
    if (done_cnt !== 1) begin errors++; $display("FAIL busy_protect done_pulses: got %0d expected 1", done_cnt); end
    checks++;
    if (done_edge !== 9) begin errors++; $display("FAIL busy_protect done_edge: got %0d expected 9", done_edge); end
  endtask

  task automatic test_reset_mid();
    rand_ops(12000);
    apply();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({c00, c01, c10, c11} !== {(4 * W){1'b0}}) begin
      errors++; $display("FAIL reset_mid_c: got %h expected 0", {c00, c01, c10, c11});
    end
    checks++;
    if ({busy, done, sat} !== 3'b000) begin
      errors++; $display("FAIL reset_mid_flags: got busy/done/sat=%b expected 000", {busy, done, sat});
    end
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    rand_ops(20000);
    run_op(0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_c[i] !== exp_c[i]) begin
        errors++; $display("FAIL reset_mid_rerun c[%0d]: got %0d expected %0d", i, obs_c[i], exp_c[i]);
      end
    end
    checks++;
    if (done_edge !== 9) begin errors++; $display("FAIL reset_mid_rerun done_edge: got %0d expected 9", done_edge); end
  endtask

  task automatic test_back_to_back();
    int exp1 [4];
    int obs1 [4];
    int obs2 [4];
    int edge1, edge2;
    rand_ops(12000);
    apply();
    model();
    exp1 = exp_c;
    start = 1'b1;
    @(posedge clk); #1;
    rand_ops(12000);
    apply();
    model();
    edge1 = -1;
    edge2 = -1;
    for (int e = 1; e <= 24; e++) begin
      @(posedge clk); #1;
      if (e == 10) start = 1'b0;
      if (done) begin
        capture();
        if (edge1 < 0) begin
          edge1 = e;
          obs1 = obs_c;
        end else if (edge2 < 0) begin
          edge2 = e;
          obs2 = obs_c;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (edge1 !== 9) begin errors++; $display("FAIL b2b first_done: got %0d expected 9", edge1); end
    checks++;
    if (edge2 - edge1 !== 10) begin errors++; $display("FAIL b2b period: got %0d expected 10", edge2 - edge1); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs1[i] !== exp1[i]) begin
        errors++; $display("FAIL b2b op1 c[%0d]: got %0d expected %0d", i, obs1[i], exp1[i]);
      end
      checks++;
      if (obs2[i] !== exp_c[i]) begin
        errors++; $display("FAIL b2b op2 c[%0d]: got %0d expected %0d", i, obs2[i], exp_c[i]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    set_ops(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    apply();
    #12;
    test_reset();
    test_identity();
    test_transpose();
    test_add_round();
    test_saturation();
    test_random();
    test_busy_protection();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
